// File: rtl/pos_input_ring_node.sv
// One node of the unidirectional position input ring: injects local positions,
// forwards upstream traffic with priority, and delivers neighbour-cell packets to the PE.
module pos_input_ring_node #(
    parameter int GCELL_X              = 0,
    parameter int GCELL_Y              = 0,
    parameter int GCELL_Z              = 0,
    parameter int X_DIM                = 3,
    parameter int Y_DIM                = 3,
    parameter int Z_DIM                = 3,
    parameter int NUM_CELLS            = X_DIM * Y_DIM * Z_DIM,
    parameter int MAX_HOPS             = 26,
    parameter int INJ_FIFO_DEPTH       = 16,
    parameter int FLOAT_STRUCT_WIDTH   = 96,
    parameter int PARTICLE_ID_WIDTH    = 8,
    parameter int GLOBAL_CELL_ID_WIDTH = 2,
    parameter int HOP_WIDTH            = $clog2(NUM_CELLS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLOAT_STRUCT_WIDTH-1:0]     i_pos,
    input  logic [PARTICLE_ID_WIDTH-1:0]      i_parid,
    input  logic                              i_pos_valid,
    output logic                              o_pos_ready,
    input  logic [FLOAT_STRUCT_WIDTH-1:0]     i_source_pos,
    input  logic [PARTICLE_ID_WIDTH-1:0]      i_source_parid,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_source_gcid,
    input  logic [HOP_WIDTH-1:0]              i_source_hops,
    input  logic                              i_source_valid,
    output logic [FLOAT_STRUCT_WIDTH-1:0]     o_dest_pos,
    output logic [PARTICLE_ID_WIDTH-1:0]      o_dest_parid,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_dest_gcid,
    output logic [HOP_WIDTH-1:0]              o_dest_hops,
    output logic                              o_dest_valid,
    output logic [FLOAT_STRUCT_WIDTH-1:0]     o_pos_to_pe,
    output logic [PARTICLE_ID_WIDTH-1:0]      o_parid_to_pe,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_gcid_to_pe,
    output logic                              o_pos_to_pe_valid,
    output logic                              o_buffer_empty,
    output logic                              o_inj_overflow
);
    localparam int GCW = GLOBAL_CELL_ID_WIDTH;
    localparam int GW  = 3 * GCW;
    localparam int FW  = FLOAT_STRUCT_WIDTH;
    localparam int PW  = PARTICLE_ID_WIDTH;
    localparam int EW  = FW + PW;
    localparam int AW  = $clog2(INJ_FIFO_DEPTH);
    localparam logic [GW-1:0] OWN_GCID = {GCW'(GCELL_X), GCW'(GCELL_Y), GCW'(GCELL_Z)};

    logic [EW-1:0]        r_mem [INJ_FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    logic [FW-1:0]        r_dest_pos, r_pe_pos;
    logic [PW-1:0]        r_dest_parid, r_pe_parid;
    logic [GW-1:0]        r_dest_gcid, r_pe_gcid;
    logic [HOP_WIDTH-1:0] r_dest_hops;
    logic                 r_dest_valid, r_pe_valid, r_overflow;

    logic                 w_full, w_empty, w_pos_ready, w_push, w_fwd, w_pop, w_deliver;
    logic [HOP_WIDTH:0]   w_hops_inc;
    logic [EW-1:0]        w_rd_data;
    logic [2:0]           w_dim_near;

    assign w_full      = (r_count == (AW+1)'(INJ_FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pos_ready = !w_full && !rst;
    assign w_push      = i_pos_valid && w_pos_ready;
    // One extra bit so hops+1 never wraps before the compare.
    assign w_hops_inc  = {1'b0, i_source_hops} + 1'b1;
    assign w_fwd       = i_source_valid && (w_hops_inc < (HOP_WIDTH+1)'(MAX_HOPS));
    assign w_pop       = !w_fwd && !w_empty;
    assign w_rd_data   = r_mem[r_rd_ptr];

    // Per-dimension periodic neighbour test against elaboration-time own/+1/-1 coordinates.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dim
            localparam int DIM = (gi == 0) ? X_DIM : (gi == 1) ? Y_DIM : Z_DIM;
            localparam int OWN = (gi == 0) ? GCELL_X : (gi == 1) ? GCELL_Y : GCELL_Z;
            localparam logic [GCW-1:0] C_OWN = GCW'(OWN);
            localparam logic [GCW-1:0] C_UP  = GCW'((OWN == DIM-1) ? 0 : OWN + 1);
            localparam logic [GCW-1:0] C_DN  = GCW'((OWN == 0) ? DIM - 1 : OWN - 1);
            logic [GCW-1:0] w_src;
            assign w_src         = i_source_gcid[(2-gi)*GCW +: GCW];
            assign w_dim_near[gi] = (w_src == C_OWN) || (w_src == C_UP) || (w_src == C_DN);
        end
    endgenerate

    assign w_deliver = i_source_valid && (&w_dim_near) && (i_source_gcid != OWN_GCID);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_pos, i_parid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_dest_pos   <= '0;
            r_dest_parid <= '0;
            r_dest_gcid  <= '0;
            r_dest_hops  <= '0;
            r_dest_valid <= 1'b0;
            r_pe_pos     <= '0;
            r_pe_parid   <= '0;
            r_pe_gcid    <= '0;
            r_pe_valid   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_pos_valid && w_full) r_overflow <= 1'b1;

            r_dest_valid <= w_fwd || w_pop;
            if (w_fwd) begin
                r_dest_pos   <= i_source_pos;
                r_dest_parid <= i_source_parid;
                r_dest_gcid  <= i_source_gcid;
                r_dest_hops  <= w_hops_inc[HOP_WIDTH-1:0];
            end else if (w_pop) begin
                r_dest_pos   <= w_rd_data[EW-1:PW];
                r_dest_parid <= w_rd_data[PW-1:0];
                r_dest_gcid  <= OWN_GCID;
                r_dest_hops  <= '0;
            end

            r_pe_valid <= w_deliver;
            if (w_deliver) begin
                r_pe_pos   <= i_source_pos;
                r_pe_parid <= i_source_parid;
                r_pe_gcid  <= i_source_gcid;
            end
        end
    end

    assign o_pos_ready       = w_pos_ready;
    assign o_buffer_empty    = w_empty;
    assign o_inj_overflow    = r_overflow;
    assign o_dest_pos        = r_dest_pos;
    assign o_dest_parid      = r_dest_parid;
    assign o_dest_gcid       = r_dest_gcid;
    assign o_dest_hops       = r_dest_hops;
    assign o_dest_valid      = r_dest_valid;
    assign o_pos_to_pe       = r_pe_pos;
    assign o_parid_to_pe     = r_pe_parid;
    assign o_gcid_to_pe      = r_pe_gcid;
    assign o_pos_to_pe_valid = r_pe_valid;
endmodule

// File: tb/tb_pos_input_ring_node.sv
// Directed bench for pos_input_ring_node at cell (0,0,0) of a 3x3x3 grid, MAX_HOPS=26, 16-deep FIFO.
module tb_pos_input_ring_node;
    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] i_pos;
    logic [7:0]  i_parid;
    logic        i_pos_valid;
    logic        o_pos_ready;
    logic [95:0] i_source_pos;
    logic [7:0]  i_source_parid;
    logic [5:0]  i_source_gcid;
    logic [4:0]  i_source_hops;
    logic        i_source_valid;
    logic [95:0] o_dest_pos;
    logic [7:0]  o_dest_parid;
    logic [5:0]  o_dest_gcid;
    logic [4:0]  o_dest_hops;
    logic        o_dest_valid;
    logic [95:0] o_pos_to_pe;
    logic [7:0]  o_parid_to_pe;
    logic [5:0]  o_gcid_to_pe;
    logic        o_pos_to_pe_valid;
    logic        o_buffer_empty;
    logic        o_inj_overflow;

    int n_total = 0;
    int n_bad   = 0;

    pos_input_ring_node dut (
        .clk(clk), .rst(rst),
        .i_pos(i_pos), .i_parid(i_parid), .i_pos_valid(i_pos_valid), .o_pos_ready(o_pos_ready),
        .i_source_pos(i_source_pos), .i_source_parid(i_source_parid), .i_source_gcid(i_source_gcid),
        .i_source_hops(i_source_hops), .i_source_valid(i_source_valid),
        .o_dest_pos(o_dest_pos), .o_dest_parid(o_dest_parid), .o_dest_gcid(o_dest_gcid),
        .o_dest_hops(o_dest_hops), .o_dest_valid(o_dest_valid),
        .o_pos_to_pe(o_pos_to_pe), .o_parid_to_pe(o_parid_to_pe), .o_gcid_to_pe(o_gcid_to_pe),
        .o_pos_to_pe_valid(o_pos_to_pe_valid),
        .o_buffer_empty(o_buffer_empty), .o_inj_overflow(o_inj_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic v, input logic [7:0] pid, input logic [5:0] gc, input logic [4:0] hops);
        i_source_valid = v;
        i_source_parid = pid;
        i_source_pos   = {12{pid ^ 8'h5A}};
        i_source_gcid  = gc;
        i_source_hops  = hops;
    endtask

    task automatic push(input logic v, input logic [7:0] pid);
        i_pos_valid = v;
        i_parid     = pid;
        i_pos       = {12{pid}};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        push(1'b0, 8'h00);
        set_src(1'b0, 8'h00, 6'h00, 5'd0);
        tick();
        tick();
        // reset state
        chk("rst_ready", o_pos_ready, 0);
        chk("rst_dest_valid", o_dest_valid, 0);
        chk("rst_empty", o_buffer_empty, 1);
        chk("rst_ovf", o_inj_overflow, 0);
        chk("rst_pe_valid", o_pos_to_pe_valid, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", o_pos_ready, 1);

        // 1: single push on idle ring
        push(1'b1, 8'd5);
        tick();
        push(1'b0, 8'd0);
        chk("t1_lat1_valid", o_dest_valid, 0);
        chk("t1_lat1_empty", o_buffer_empty, 0);
        tick();
        chk("t1_valid", o_dest_valid, 1);
        chk("t1_parid", o_dest_parid, 5);
        chk("t1_pos", o_dest_pos, {12{8'd5}});
        chk("t1_gcid", o_dest_gcid, 0);
        chk("t1_hops", o_dest_hops, 0);
        chk("t1_empty", o_buffer_empty, 1);
        tick();
        chk("t1_idle", o_dest_valid, 0);

        // 2: ring saturated for 20 cycles, 4 entries queued in first 4 cycles
        for (int k = 0; k < 20; k++) begin
            set_src(1'b1, 8'(40 + k), 6'b010101, 5'd3);
            push(k < 4, 8'(10 + k));
            tick();
            chk("t2_fwd_valid", o_dest_valid, 1);
            chk("t2_fwd_parid", o_dest_parid, 40 + k);
            chk("t2_fwd_hops", o_dest_hops, 4);
        end
        chk("t2_pe_valid", o_pos_to_pe_valid, 1);
        chk("t2_queued", o_buffer_empty, 0);
        set_src(1'b0, 8'd0, 6'd0, 5'd0);
        push(1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_drain_valid", o_dest_valid, 1);
            chk("t2_drain_parid", o_dest_parid, 10 + k);
            chk("t2_drain_hops", o_dest_hops, 0);
            chk("t2_drain_gcid", o_dest_gcid, 0);
        end
        chk("t2_empty", o_buffer_empty, 1);
        tick();
        chk("t2_idle", o_dest_valid, 0);

        // 3: delivery across the wrap and self-origin suppression
        set_src(1'b1, 8'd33, 6'b101010, 5'd0);
        tick();
        chk("t3_wrap_pe_valid", o_pos_to_pe_valid, 1);
        chk("t3_wrap_pe_gcid", o_gcid_to_pe, 6'b101010);
        chk("t3_wrap_pe_parid", o_parid_to_pe, 33);
        chk("t3_wrap_pe_pos", o_pos_to_pe, {12{8'd33 ^ 8'h5A}});
        set_src(1'b1, 8'd34, 6'b000000, 5'd0);
        tick();
        chk("t3_self_pe_valid", o_pos_to_pe_valid, 0);
        set_src(1'b1, 8'd35, 6'b000100, 5'd0);
        tick();
        chk("t3_y1_pe_valid", o_pos_to_pe_valid, 1);
        set_src(1'b0, 8'd0, 6'd0, 5'd0);
        tick();
        chk("t3_idle_pe_valid", o_pos_to_pe_valid, 0);

        // 4: retirement frees the slot for a queued entry
        set_src(1'b1, 8'd60, 6'b010000, 5'd3);
        push(1'b1, 8'd77);
        tick();
        push(1'b0, 8'd0);
        chk("t4_fwd_parid", o_dest_parid, 60);
        set_src(1'b1, 8'd61, 6'b010000, 5'd25);
        tick();
        chk("t4_inj_valid", o_dest_valid, 1);
        chk("t4_inj_parid", o_dest_parid, 77);
        chk("t4_inj_hops", o_dest_hops, 0);
        chk("t4_ret_pe_valid", o_pos_to_pe_valid, 1);
        chk("t4_ret_pe_parid", o_parid_to_pe, 61);
        set_src(1'b1, 8'd62, 6'b010000, 5'd24);
        tick();
        chk("t4_h24_valid", o_dest_valid, 1);
        chk("t4_h24_hops", o_dest_hops, 25);
        chk("t4_h24_parid", o_dest_parid, 62);
        set_src(1'b1, 8'd63, 6'b010000, 5'd25);
        tick();
        chk("t4_ret_empty_valid", o_dest_valid, 0);
        set_src(1'b0, 8'd0, 6'd0, 5'd0);
        chk("t4_ovf", o_inj_overflow, 0);

        // 5: 17 pushes into 16-deep FIFO with ring saturated
        for (int k = 0; k < 17; k++) begin
            set_src(1'b1, 8'd90, 6'b000001, 5'd0);
            chk("t5_ready", o_pos_ready, (k < 16) ? 1 : 0);
            push(1'b1, 8'(8'h80 + k));
            tick();
            if (k == 15) chk("t5_ovf_pre", o_inj_overflow, 0);
        end
        push(1'b0, 8'd0);
        chk("t5_ovf", o_inj_overflow, 1);
        chk("t5_ready_full", o_pos_ready, 0);
        set_src(1'b0, 8'd0, 6'd0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t5_drain_valid", o_dest_valid, 1);
            chk("t5_drain_parid", o_dest_parid, 8'h80 + k);
        end
        chk("t5_empty", o_buffer_empty, 1);
        tick();
        chk("t5_idle", o_dest_valid, 0);
        chk("t5_ovf_sticky", o_inj_overflow, 1);

        // 6: reset mid-operation
        for (int k = 0; k < 8; k++) begin
            set_src(1'b1, 8'd120, 6'b000001, 5'd1);
            push(1'b1, 8'(8'hC0 + k));
            tick();
        end
        push(1'b0, 8'd0);
        chk("t6_pre_valid", o_dest_valid, 1);
        chk("t6_pre_empty", o_buffer_empty, 0);
        set_src(1'b0, 8'd0, 6'd0, 5'd0);
        rst = 1'b1;
        tick();
        chk("t6_dest_valid", o_dest_valid, 0);
        chk("t6_dest_parid", o_dest_parid, 0);
        chk("t6_dest_hops", o_dest_hops, 0);
        chk("t6_dest_gcid", o_dest_gcid, 0);
        chk("t6_pe_valid", o_pos_to_pe_valid, 0);
        chk("t6_pe_parid", o_parid_to_pe, 0);
        chk("t6_ovf", o_inj_overflow, 0);
        chk("t6_empty", o_buffer_empty, 1);
        chk("t6_ready", o_pos_ready, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_stale", o_dest_valid, 0);
        end
        chk("t6_empty_after", o_buffer_empty, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
